apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, number of consecutive ACCESS cycles with pready low before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port: pclk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: req0  in  1  requester 0 transfer request, held until done[0].
REQ-005 SHALL have port: we0  in  1  requester 0 write (1) / read (0).
REQ-006 SHALL have port: addr0  in  8  requester 0 address.
REQ-007 SHALL have port: wdata0  in  16  requester 0 write data.
REQ-008 SHALL have ports: req1, we1, addr1, wdata1, identical to the requester 0 ports, for requester 1.
REQ-009 SHALL have port: done  out  2  one-hot, one-cycle completion pulse per requester.
REQ-010 SHALL have port: rdata  out  16  read data, valid in done cycle.
REQ-011 SHALL have port: err  out  1  timeout flag, valid in done cycle.
REQ-012 SHALL have ports: psel, penable, pwrite (out 1); paddr (out 8); pwdata (out 16) as APB master outputs.
REQ-013 SHALL have ports: prdata  in  16; pready  in  1  from APB slave.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-015 IDLE: if req0|req1, SHALL grant one requester, latch its we/addr/wdata into pwrite/paddr/pwdata, assert psel=1, penable=0, go SETUP; else stay IDLE with psel=0.
REQ-016 SETUP: SHALL hold psel=1, assert penable=1 next cycle, go ACCESS unconditionally.
REQ-017 ACCESS: on pready=1 SHALL deassert psel/penable, pulse done[granted]=1 for one cycle, load rdata=prdata on reads (rdata unchanged on writes), err=0, and go IDLE.
REQ-018 ACCESS with pready=0 SHALL hold psel, penable, paddr, pwdata, pwrite stable.
REQ-019 Latency: req asserted in IDLE at edge T, psel=1 after T+1, penable=1 after T+2, done after T+3 with zero-wait slave.
REQ-020 Arbitration SHALL be round-robin: a 1-bit last-grant pointer; on simultaneous req0 and req1, grant the requester not last granted; a single request is always granted.
REQ-021 Pointer SHALL update only on grant in IDLE.
REQ-022 Command latched at grant SHALL be immune to requester input changes during SETUP/ACCESS.
REQ-023 FSM SHALL return to IDLE for at least one cycle between transfers; the requester SHALL drop req in the cycle after done, otherwise it is re-arbitrated.
REQ-024 Request dropped before grant SHALL be ignored; request dropped after grant SHALL NOT abort the transfer.
REQ-025 done SHALL never have both bits set; err=0 whenever done=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force FSM=IDLE, psel=penable=pwrite=0, paddr=0, pwdata=0, rdata=0, done=0, err=0, pointer=requester 1 (so requester 0 wins the first tie).
REQ-027 rst SHALL override any state, including mid-SETUP/ACCESS; the aborted transfer produces no done pulse.

Configuration
REQ-028 Macro APB_ARB_TIMEOUT_EN defined: SHALL count consecutive ACCESS cycles with pready=0; when the count reaches TIMEOUT_CYC, SHALL end the transfer as in REQ-017 but with err=1 and rdata=16'h0000; counter clears on leaving ACCESS.
REQ-029 Macro APB_ARB_TIMEOUT_EN undefined: SHALL wait in ACCESS indefinitely for pready; err tied 0; no counter logic.

Verification
REQ-030 Only req0=1, we0=1, addr0=8'h12, wdata0=16'hA5A5, pready=1 -> psel at T+1, penable at T+2, paddr=8'h12, pwdata=16'hA5A5, done=2'b01 at T+3, err=0.
REQ-031 req0 and req1 both held from reset (reads 8'h01 / 8'h02) -> grants alternate 0,1,0,1; done sequence 01,10,01,10.
REQ-032 Read addr1=8'h40, pready low 3 ACCESS cycles, prdata=16'hBEEF -> APB outputs stable throughout; done=2'b10, rdata=16'hBEEF one cycle after pready rises.
REQ-033 rst asserted during ACCESS -> next cycle all outputs 0, FSM IDLE, no done pulse.
REQ-034 APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, pready held 0 -> after 16 ACCESS cycles done pulses with err=1, rdata=16'h0000; without macro, done stays 0 indefinitely.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle shared by apb_req_arbiter and the slave it drives.
interface apb_req_arbiter_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter issuing single APB transfers (IDLE/SETUP/ACCESS).
// Optional ACCESS-phase timeout abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                req0,
  input  logic                we0,
  input  logic [7:0]          addr0,
  input  logic [15:0]         wdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [7:0]          addr1,
  input  logic [15:0]         wdata1,
  output logic [1:0]          done,
  output logic [15:0]         rdata,
  output logic                err,
  apb_req_arbiter_if.master   apb
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  if (TIMEOUT_CYC < 1) begin : g_param_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]       state;
  logic             last_gnt;
  logic             gnt;
  logic             gnt_sel;
  logic             xfer_end;
  logic             abort;

  logic [1:0]       req_v;
  logic [1:0]       we_v;
  logic [1:0][7:0]  addr_v;
  logic [1:0][15:0] wdata_v;

  assign req_v   = {req1, req0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    gnt_sel = last_gnt;
    case (req_v)
      2'b01:   gnt_sel = 1'b0;
      2'b10:   gnt_sel = 1'b1;
      2'b11:   gnt_sel = ~last_gnt;
      default: gnt_sel = last_gnt;
    endcase
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Counts stalled ACCESS cycles; the final stalled cycle ends the transfer.
  assign abort = (state == ACCESS) && !apb.pready &&
                 (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk) begin
    if (rst || state != ACCESS || apb.pready || abort)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge pclk) begin
    if (rst)
      err_q <= 1'b0;
    else
      err_q <= abort;
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  assign xfer_end = (state == ACCESS) && (apb.pready || abort);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      gnt         <= 1'b0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      rdata       <= '0;
      done        <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          apb.psel    <= 1'b0;
          apb.penable <= 1'b0;
          if (|req_v) begin
            gnt         <= gnt_sel;
            last_gnt    <= gnt_sel;
            apb.psel    <= 1'b1;
            apb.pwrite  <= we_v[gnt_sel];
            apb.paddr   <= addr_v[gnt_sel];
            apb.pwdata  <= wdata_v[gnt_sel];
            state       <= SETUP;
          end
        end
        SETUP: begin
          apb.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (xfer_end) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            done[gnt]   <= 1'b1;
            state       <= IDLE;
            if (abort)
              rdata <= '0;
            else if (!apb.pwrite)
              rdata <= apb.prdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: expected completions queued at stimulus time.
module tb_apb_req_arbiter;
  typedef struct packed {
    logic [1:0]  done;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        err;
  logic        pready_tb = 1'b1;
  logic        use_ovr = 1'b0;
  logic [15:0] ovr = '0;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  exp_t e;

  apb_req_arbiter_if apb();

  // Slave model: zero/variable wait, read data derived from the address unless overridden.
  assign apb.pready = pready_tb;
  assign apb.prdata = use_ovr ? ovr : {apb.paddr, ~apb.paddr};

  apb_req_arbiter #(.TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done(done), .rdata(rdata), .err(err),
    .apb(apb)
  );

  always #5 pclk = ~pclk;

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (done !== 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== 27'd0)
      $display("FAIL reset_bus: got %h want 0",
               {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata});
    else passed++;
    checks++;
    if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rdata);
    else passed++;
    checks++;
    if ({done, err} !== 3'b000) $display("FAIL reset_done_err: got %b want 000", {done, err});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_read_wait;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
    pready_tb = 1'b0; use_ovr = 1'b1; ovr = 16'hBEEF;
    sb.push_back('{done: 2'b10, rdata: 16'hBEEF, err: 1'b0});
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr} !== {3'b100, 8'h40})
      $display("FAIL rd_setup: got %h want %h", {apb.psel, apb.penable, apb.pwrite, apb.paddr}, {3'b100, 8'h40});
    else passed++;
    addr1 = 8'hFF; we1 = 1'b1;
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr} !== {3'b110, 8'h40})
      $display("FAIL rd_access: got %h want %h", {apb.psel, apb.penable, apb.pwrite, apb.paddr}, {3'b110, 8'h40});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++;
      if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, done} !== {3'b110, 8'h40, 2'b00})
        $display("FAIL rd_wait_stable%0d: got %h want %h", i,
                 {apb.psel, apb.penable, apb.pwrite, apb.paddr, done}, {3'b110, 8'h40, 2'b00});
      else passed++;
    end
    pready_tb = 1'b1;
    @(negedge pclk);
    e = sb.pop_front();
    checks++;
    if ({done, rdata, err} !== {e.done, e.rdata, e.err})
      $display("FAIL rd_done: got done=%b rdata=%h err=%b want done=%b rdata=%h err=%b",
               done, rdata, err, e.done, e.rdata, e.err);
    else passed++;
    req1 = 1'b0; we1 = 1'b0; use_ovr = 1'b0;
  endtask

  task automatic test_single_write;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h12; wdata0 = 16'hA5A5;
    sb.push_back('{done: 2'b01, rdata: 16'hBEEF, err: 1'b0});
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {3'b101, 8'h12, 16'hA5A5})
      $display("FAIL wr_setup: got %h want %h",
               {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, {3'b101, 8'h12, 16'hA5A5});
    else passed++;
    addr0 = 8'h00; wdata0 = 16'h0000; we0 = 1'b0;
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {3'b111, 8'h12, 16'hA5A5})
      $display("FAIL wr_access: got %h want %h",
               {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, {3'b111, 8'h12, 16'hA5A5});
    else passed++;
    @(negedge pclk);
    e = sb.pop_front();
    checks++;
    if ({done, rdata, err, apb.psel} !== {e.done, e.rdata, e.err, 1'b0})
      $display("FAIL wr_done: got done=%b rdata=%h err=%b psel=%b want done=%b rdata=%h err=%b psel=0",
               done, rdata, err, apb.psel, e.done, e.rdata, e.err);
    else passed++;
    req0 = 1'b0;
    @(negedge pclk);
    checks++;
    if (done !== 2'b00) $display("FAIL wr_done_pulse: got %b want 00", done);
    else passed++;
  endtask

  task automatic test_back_to_back_rr;
    bit ok;
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{done: 2'b01, rdata: 16'h01FE, err: 1'b0});
      sb.push_back('{done: 2'b10, rdata: 16'h02FD, err: 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      wait_done(ok);
      e = sb.pop_front();
      checks++;
      if (!ok)
        $display("FAIL rr_timeout%0d: got no done want done=%b", i, e.done);
      else if ({done, rdata, err, apb.psel} !== {e.done, e.rdata, e.err, 1'b0})
        $display("FAIL rr_done%0d: got done=%b rdata=%h err=%b psel=%b want done=%b rdata=%h err=%b psel=0",
                 i, done, rdata, err, apb.psel, e.done, e.rdata, e.err);
      else passed++;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_timeout;
    logic seen;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33; pready_tb = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if (apb.penable !== 1'b1) $display("FAIL tmo_enter_access: got %b want 1", apb.penable);
    else passed++;
    seen = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    sb.push_back('{done: 2'b01, rdata: 16'h0000, err: 1'b1});
    for (int i = 0; i < 15; i++) begin
      @(negedge pclk);
      seen = seen | (|done) | err;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL tmo_early: got done/err before limit want none");
    else passed++;
    @(negedge pclk);
    e = sb.pop_front();
    checks++;
    if ({done, rdata, err, apb.psel} !== {e.done, e.rdata, e.err, 1'b0})
      $display("FAIL tmo_done: got done=%b rdata=%h err=%b psel=%b want done=%b rdata=%h err=%b psel=0",
               done, rdata, err, apb.psel, e.done, e.rdata, e.err);
    else passed++;
    req0 = 1'b0;
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      seen = seen | (|done) | err;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL no_tmo_done: got done/err while stalled want none");
    else passed++;
    checks++;
    if ({apb.psel, apb.penable, apb.paddr} !== {2'b11, 8'h33})
      $display("FAIL no_tmo_hold: got %h want %h", {apb.psel, apb.penable, apb.paddr}, {2'b11, 8'h33});
    else passed++;
`endif
    req0 = 1'b0; pready_tb = 1'b1;
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic seen;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 16'h1234; pready_tb = 1'b0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable} !== 2'b11) $display("FAIL mid_in_access: got %b want 11", {apb.psel, apb.penable});
    else passed++;
    rst = 1'b1; req0 = 1'b0;
    @(negedge pclk);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, done, err, rdata} !== 46'd0)
      $display("FAIL mid_reset_outputs: got %h want 0",
               {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, done, err, rdata});
    else passed++;
    rst = 1'b0; pready_tb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      seen = seen | (|done) | apb.psel;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL mid_no_done: got activity after reset want none");
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    @(negedge pclk);
    test_reset();
    test_read_wait();
    test_single_write();
    test_back_to_back_rr();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
